// File: rtl/buffet_read_arbiter.sv
// Round-robin arbiter sharing one buffet read/shrink port between two consumers,
// with an in-order tag FIFO that steers each read response back to its issuer.
//
// Lock FSM:
//   state     | meaning
//   ST_OPEN   | grant computed fresh each cycle from eligible requesters
//   ST_LOCKED | buffet stalled a request; grant frozen on lock_sel_q until accept
module buffet_read_arbiter #(
    parameter int IDX_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset_i,
    input  logic [IDX_WIDTH-1:0]             r0_idx,
    input  logic                             r0_idx_valid,
    input  logic                             r0_is_shrink,
    input  logic                             r0_will_update,
    output logic                             r0_idx_ready,
    output logic [DATA_WIDTH-1:0]            r0_data,
    output logic                             r0_data_valid,
    input  logic                             r0_data_ready,
    input  logic [IDX_WIDTH-1:0]             r1_idx,
    input  logic                             r1_idx_valid,
    input  logic                             r1_is_shrink,
    input  logic                             r1_will_update,
    output logic                             r1_idx_ready,
    output logic [DATA_WIDTH-1:0]            r1_data,
    output logic                             r1_data_valid,
    input  logic                             r1_data_ready,
    output logic [IDX_WIDTH-1:0]             read_idx,
    output logic                             read_idx_valid,
    input  logic                             read_idx_ready,
    output logic                             is_shrink,
    output logic                             read_will_update,
    input  logic [DATA_WIDTH-1:0]            read_data,
    input  logic                             read_data_valid,
    output logic                             read_data_ready,
    output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding_o,
    output logic                             err_o
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

    lock_state_t      state_q, state_d;
    logic             lock_sel_q, lock_sel_d;
    logic             rr_ptr_q;
    logic             tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic fifo_full, fifo_empty, head_sel;
    logic elig0, elig1;
    logic gnt_sel, gnt_valid;
    logic req_valid, xfer, push, pop, rsp_ready;

    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_sel   = tag_mem[rd_ptr_q];

    // A pop in the same cycle never frees a slot for a read: eligibility looks at the registered count.
    assign elig0 = r0_idx_valid & (r0_is_shrink | ~fifo_full);
    assign elig1 = r1_idx_valid & (r1_is_shrink | ~fifo_full);

    always_comb begin
        gnt_sel   = 1'b0;
        gnt_valid = 1'b0;
        if (state_q == ST_LOCKED) begin
            gnt_sel   = lock_sel_q;
            gnt_valid = lock_sel_q ? r1_idx_valid : r0_idx_valid;
        end else if (elig0 && elig1) begin
            gnt_sel   = rr_ptr_q;
            gnt_valid = 1'b1;
        end else begin
            gnt_sel   = elig1;
            gnt_valid = elig0 | elig1;
        end
    end

    assign req_valid = gnt_valid & ~reset_i;
    assign xfer      = req_valid & read_idx_ready;

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        if (state_q == ST_OPEN) begin
            if (req_valid && !read_idx_ready) begin
                state_d    = ST_LOCKED;
                lock_sel_d = gnt_sel;
            end
        end else if (xfer) begin
            state_d = ST_OPEN;
        end
    end

    assign read_idx_valid   = req_valid;
    assign read_idx         = gnt_sel ? r1_idx : r0_idx;
    assign is_shrink        = gnt_sel ? r1_is_shrink : r0_is_shrink;
    assign read_will_update = gnt_sel ? r1_will_update : r0_will_update;
    assign r0_idx_ready     = xfer & ~gnt_sel;
    assign r1_idx_ready     = xfer & gnt_sel;
    assign push             = xfer & ~is_shrink;

    // With no tag outstanding a stray beat is accepted and dropped so the buffet cannot wedge.
    assign rsp_ready       = fifo_empty ? 1'b1 : (head_sel ? r1_data_ready : r0_data_ready);
    assign read_data_ready = rsp_ready & ~reset_i;
    assign r0_data_valid   = read_data_valid & ~fifo_empty & ~head_sel & ~reset_i;
    assign r1_data_valid   = read_data_valid & ~fifo_empty & head_sel & ~reset_i;
    assign r0_data         = read_data;
    assign r1_data         = read_data;
    assign pop             = read_data_valid & read_data_ready & ~fifo_empty;

    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= ST_OPEN;
            lock_sel_q <= 1'b0;
            rr_ptr_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            if (xfer) rr_ptr_q <= ~gnt_sel;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
            if (read_data_valid && fifo_empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr_q] <= gnt_sel;
    end

endmodule

// File: tb/tb_buffet_read_arbiter.sv
// Bench for buffet_read_arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference of the arbitration and response-routing rules.
module tb_buffet_read_arbiter;
    localparam int IW = 8;
    localparam int DW = 32;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset_i;
    logic [IW-1:0] ridx [2];
    logic rv [2];
    logic rsh [2];
    logic rwu [2];
    logic rdr [2];
    logic r0_idx_ready, r1_idx_ready, r0_data_valid, r1_data_valid;
    logic [DW-1:0] r0_data, r1_data;
    logic [IW-1:0] read_idx;
    logic read_idx_valid, read_idx_ready, is_shrink, read_will_update;
    logic [DW-1:0] read_data;
    logic read_data_valid, read_data_ready;
    logic [2:0] outstanding_o;
    logic err_o;

    always #5 clk = ~clk;

    buffet_read_arbiter #(.IDX_WIDTH(IW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .reset_i(reset_i),
        .r0_idx(ridx[0]), .r0_idx_valid(rv[0]), .r0_is_shrink(rsh[0]), .r0_will_update(rwu[0]),
        .r0_idx_ready(r0_idx_ready), .r0_data(r0_data), .r0_data_valid(r0_data_valid), .r0_data_ready(rdr[0]),
        .r1_idx(ridx[1]), .r1_idx_valid(rv[1]), .r1_is_shrink(rsh[1]), .r1_will_update(rwu[1]),
        .r1_idx_ready(r1_idx_ready), .r1_data(r1_data), .r1_data_valid(r1_data_valid), .r1_data_ready(rdr[1]),
        .read_idx(read_idx), .read_idx_valid(read_idx_valid), .read_idx_ready(read_idx_ready),
        .is_shrink(is_shrink), .read_will_update(read_will_update),
        .read_data(read_data), .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    int total = 0;
    int bad = 0;
    // Reference state: issuers of outstanding reads, last accepted requester, frozen grant, sticky error.
    int q[$];
    int last = 1;
    int held = -1;
    bit err_m = 1'b0;
    bit acc [2];
    int oglog[$];
    int oidx[$];
    int odlv[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int n = 0; n < 2; n++) begin
            rv[n] = 1'b0; rsh[n] = 1'b0; rwu[n] = 1'b0; rdr[n] = 1'b1; ridx[n] = '0;
        end
        read_idx_ready = 1'b1;
        read_data_valid = 1'b0;
        read_data = '0;
    endtask

    // Check all outputs against the reference for the current inputs, then advance one clock.
    task automatic cycle();
        bit e0, e1, gv, xf, emp, rdyx;
        bit dvx [2];
        int g, hd;
        #1;
        emp = (q.size() == 0);
        e0 = rv[0] && (rsh[0] || q.size() < TD);
        e1 = rv[1] && (rsh[1] || q.size() < TD);
        if (held >= 0) begin
            g = held; gv = rv[held];
        end else if (e0 && e1) begin
            g = (last == 0) ? 1 : 0; gv = 1'b1;
        end else begin
            g = e1 ? 1 : 0; gv = e0 || e1;
        end
        if (reset_i) gv = 1'b0;
        xf = gv && read_idx_ready;
        hd = emp ? 0 : q[0];
        dvx[0] = !reset_i && !emp && hd == 0 && read_data_valid;
        dvx[1] = !reset_i && !emp && hd == 1 && read_data_valid;
        rdyx = !reset_i && (emp ? 1'b1 : rdr[hd]);
        chk("read_idx_valid", read_idx_valid, gv);
        chk("r0_idx_ready", r0_idx_ready, xf && g == 0);
        chk("r1_idx_ready", r1_idx_ready, xf && g == 1);
        chk("r0_data_valid", r0_data_valid, dvx[0]);
        chk("r1_data_valid", r1_data_valid, dvx[1]);
        chk("read_data_ready", read_data_ready, rdyx);
        if (gv) begin
            chk("read_idx", read_idx, ridx[g]);
            chk("is_shrink", is_shrink, rsh[g]);
            chk("read_will_update", read_will_update, rwu[g]);
        end
        if (dvx[0]) chk("r0_data", r0_data, read_data);
        if (dvx[1]) chk("r1_data", r1_data, read_data);
        if (!reset_i) begin
            chk("outstanding", outstanding_o, q.size());
            chk("err", err_o, err_m);
        end
        if (r0_idx_ready) begin oglog.push_back(0); oidx.push_back(int'(read_idx)); end
        if (r1_idx_ready) begin oglog.push_back(1); oidx.push_back(int'(read_idx)); end
        if (r0_data_valid && read_data_ready) odlv.push_back(0);
        if (r1_data_valid && read_data_ready) odlv.push_back(1);
        @(posedge clk);
        acc[0] = 1'b0; acc[1] = 1'b0;
        if (reset_i) begin
            q.delete(); last = 1; held = -1; err_m = 1'b0;
        end else begin
            if (read_data_valid && emp) err_m = 1'b1;
            if (read_data_valid && rdyx && !emp) void'(q.pop_front());
            if (xf) begin
                last = g; held = -1; acc[g] = 1'b1;
                if (!rsh[g]) q.push_back(g);
            end else if (gv) begin
                held = g;
            end
        end
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        rv[0] = 1'b0; rv[1] = 1'b0; rdr[0] = 1'b1; rdr[1] = 1'b1;
        while (q.size() > 0 && guard < 20) begin
            read_data_valid = 1'b1; read_data = $urandom;
            cycle();
            guard++;
        end
        chk("drain_bound", guard < 20, 1'b1);
        read_data_valid = 1'b0;
    endtask

    initial begin
        int n0, n1, guard;
        clr();
        reset_i = 1'b1;
        cycle(); cycle();
        reset_i = 1'b0;
        #1;
        chk("reset_outstanding", outstanding_o, 0);
        chk("reset_err", err_o, 0);

        // Single R0 read, response 0xA5A5A5A5.
        rv[0] = 1'b1; ridx[0] = 8'd3;
        cycle();
        rv[0] = 1'b0;
        chk("t1_out_1", outstanding_o, 1);
        read_data_valid = 1'b1; read_data = 32'hA5A5A5A5;
        #1;
        chk("t1_r0_dv", r0_data_valid, 1);
        chk("t1_r0_data", r0_data, 32'hA5A5A5A5);
        chk("t1_r1_dv", r1_data_valid, 0);
        cycle();
        read_data_valid = 1'b0;
        chk("t1_out_0", outstanding_o, 0);

        // Both requesters continuously: grants alternate starting from R0.
        reset_i = 1'b1; cycle(); reset_i = 1'b0;
        oglog.delete(); oidx.delete(); odlv.delete();
        n0 = 0; n1 = 0; guard = 0;
        while ((n0 < 2 || n1 < 2) && guard < 12) begin
            rv[0] = (n0 < 2); ridx[0] = IW'(n0 * 2);
            rv[1] = (n1 < 2); ridx[1] = IW'(n1 * 2 + 1);
            cycle();
            if (acc[0]) n0++;
            if (acc[1]) n1++;
            guard++;
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        chk("t2_grant_count", oglog.size(), 4);
        for (int i = 0; i < 4 && i < oglog.size(); i++) begin
            chk("t2_grant_order", oglog[i], i % 2);
            chk("t2_idx_order", oidx[i], i);
        end
        for (int k = 0; k < 4; k++) begin
            read_data_valid = 1'b1; read_data = 32'h100 + k;
            cycle();
        end
        read_data_valid = 1'b0;
        chk("t2_resp_count", odlv.size(), 4);
        for (int i = 0; i < 4 && i < odlv.size(); i++) chk("t2_resp_order", odlv[i], i % 2);

        // Fill the tag FIFO, then a 5th read stalls while a shrink still passes.
        for (int k = 0; k < 4; k++) begin
            rv[k % 2] = 1'b1; ridx[k % 2] = IW'(20 + k);
            cycle();
            rv[k % 2] = 1'b0;
        end
        rv[0] = 1'b1; ridx[0] = 8'd30;
        #1;
        chk("t3_out_4", outstanding_o, 4);
        chk("t3_5th_ready", r0_idx_ready, 0);
        chk("t3_5th_valid", read_idx_valid, 0);
        cycle();
        rv[1] = 1'b1; rsh[1] = 1'b1; ridx[1] = 8'd2;
        #1;
        chk("t3_shrink_valid", read_idx_valid, 1);
        chk("t3_shrink_flag", is_shrink, 1);
        chk("t3_shrink_r1_ready", r1_idx_ready, 1);
        chk("t3_shrink_r0_ready", r0_idx_ready, 0);
        cycle();
        rv[1] = 1'b0; rsh[1] = 1'b0;
        chk("t3_out_still_4", outstanding_o, 4);
        drain();

        // Lock: R0 stalled three cycles, R1 (which holds priority) arrives meanwhile.
        rv[0] = 1'b1; rsh[0] = 1'b1; cycle(); rv[0] = 1'b0; rsh[0] = 1'b0;
        rv[0] = 1'b1; ridx[0] = 8'd7; read_idx_ready = 1'b0;
        cycle();
        rv[1] = 1'b1; ridx[1] = 8'd8;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t4_lock_idx", read_idx, 8'd7);
            cycle();
        end
        read_idx_ready = 1'b1;
        #1;
        chk("t4_r0_accept", r0_idx_ready, 1);
        cycle();
        rv[0] = 1'b0;
        #1;
        chk("t4_r1_next", r1_idx_ready, 1);
        cycle();
        rv[1] = 1'b0;

        // R1 at head with data_ready low blocks the R0 response behind it.
        read_data_valid = 1'b1; cycle(); read_data_valid = 1'b0;
        rv[0] = 1'b1; ridx[0] = 8'd9; cycle(); rv[0] = 1'b0;
        read_data_valid = 1'b1; rdr[1] = 1'b0; rdr[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_rdr_low", read_data_ready, 0);
            chk("t5_r0_not_ooo", r0_data_valid, 0);
            cycle();
        end
        chk("t5_out_held", outstanding_o, 2);
        rdr[1] = 1'b1;
        cycle(); cycle();
        read_data_valid = 1'b0;
        chk("t5_out_0", outstanding_o, 0);

        // Stray beat with FIFO empty, sticky error, then reset restores R0 priority.
        read_data_valid = 1'b1;
        #1;
        chk("t6_drop_ready", read_data_ready, 1);
        cycle();
        read_data_valid = 1'b0;
        chk("t6_err_set", err_o, 1);
        cycle(); cycle();
        chk("t6_err_sticky", err_o, 1);
        reset_i = 1'b1; cycle(); reset_i = 1'b0;
        chk("t6_err_clear", err_o, 0);
        chk("t6_out_clear", outstanding_o, 0);
        rv[0] = 1'b1; rv[1] = 1'b1; ridx[0] = 8'd40; ridx[1] = 8'd41;
        #1;
        chk("t6_r0_priority", r0_idx_ready, 1);
        cycle();
        rv[0] = 1'b0;
        cycle();
        rv[1] = 1'b0;
        drain();

        // Random traffic, with one reset landing mid-operation.
        acc[0] = 1'b0; acc[1] = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!rv[n] || acc[n]) begin
                    rv[n] = ($urandom_range(0, 9) < 6);
                    ridx[n] = IW'($urandom);
                    rsh[n] = ($urandom_range(0, 3) == 0);
                    rwu[n] = 1'($urandom);
                end
                rdr[n] = ($urandom_range(0, 9) < 7);
            end
            read_idx_ready = ($urandom_range(0, 9) < 7);
            read_data = $urandom;
            read_data_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            reset_i = (i == 1500);
            cycle();
        end
        reset_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
